lds_circle_angle_sequencer: RTL and testbench



---
 rtl/lds_hw_pkg.sv | 14 +
 rtl/vdc_base2_angle.sv | 11 +
 rtl/lds_circle_angle_sequencer.sv | 106 ++++++++++
 tb/tb_lds_circle_angle_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lds_hw_pkg.sv
// Shared constants and FSM encoding for the low-discrepancy point pipeline.
package lds_hw_pkg;
  localparam int INDEX_W_DEF = 32;
  localparam int ANGLE_W_DEF = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } seq_state_e;
endpackage

// File: rtl/vdc_base2_angle.sv
// Base-2 Van der Corput angle: bit-reversed index as a fraction of a full turn.
module vdc_base2_angle #(
  parameter int ANGLE_W = 16
) (
  input  logic [ANGLE_W-1:0] idx,
  output logic [ANGLE_W-1:0] angle
);
  for (genvar i = 0; i < ANGLE_W; i++) begin : g_rev
    assign angle[i] = idx[ANGLE_W-1-i];
  end
endmodule

// File: rtl/lds_circle_angle_sequencer.sv
// Issues one CORDIC request per sequence index and streams the resulting
// cos/sin pair out as a point.
module lds_circle_angle_sequencer
  import lds_hw_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [INDEX_W-1:0] seed_value,
  input  logic               cordic_ready,
  input  logic               cordic_done,
  input  logic [DATA_W-1:0]  cordic_cos,
  input  logic [DATA_W-1:0]  cordic_sin,
  output logic               cordic_start,
  output logic [ANGLE_W-1:0] cordic_angle,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_cos,
  output logic [DATA_W-1:0]  out_sin,
  output logic [INDEX_W-1:0] out_index,
  output logic               busy,
  output logic               timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e         state;
  logic [INDEX_W-1:0] count;
  logic [INDEX_W-1:0] k;
  logic [ANGLE_W-1:0] k_angle;
  logic [TW-1:0]      tcnt;

  assign k    = count + INDEX_W'(1);
  assign busy = (state != ST_IDLE);

  vdc_base2_angle #(.ANGLE_W(ANGLE_W)) u_vdc (
    .idx   (k[ANGLE_W-1:0]),
    .angle (k_angle)
  );

  // Request fields are registered on the IDLE->ISSUE edge so that start,
  // angle and the bumped count are all visible during the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      tcnt         <= '0;
      cordic_start <= 1'b0;
      cordic_angle <= '0;
      out_valid    <= 1'b0;
      out_cos      <= '0;
      out_sin      <= '0;
      out_index    <= '0;
      timeout_err  <= 1'b0;
    end else if (seed_load) begin
      state        <= ST_IDLE;
      count        <= seed_value;
      cordic_start <= 1'b0;
      out_valid    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable && cordic_ready) begin
            state        <= ST_ISSUE;
            cordic_start <= 1'b1;
            count        <= k;
            cordic_angle <= k_angle;
          end
        end
        ST_ISSUE: begin
          state        <= ST_WAIT;
          cordic_start <= 1'b0;
          tcnt         <= '0;
        end
        ST_WAIT: begin
          if (cordic_done) begin
            state     <= ST_HOLD;
            out_cos   <= cordic_cos;
            out_sin   <= cordic_sin;
            out_index <= count;
            out_valid <= 1'b1;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Abandon this k; the count stays advanced so it is skipped.
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lds_circle_angle_sequencer.sv
// Bench for lds_circle_angle_sequencer with a latency-programmable CORDIC stand-in.
module tb_lds_circle_angle_sequencer;
  localparam int IW = 32, AW = 16, DW = 32, TO = 64;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          enable = 1'b0, seed_load = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] seed_value = '0;
  logic          cordic_ready, cordic_done, cordic_start;
  logic [DW-1:0] cordic_cos, cordic_sin, out_cos, out_sin;
  logic [AW-1:0] cordic_angle;
  logic          out_valid, busy, timeout_err;
  logic [IW-1:0] out_index;

  int errors = 0, checks = 0, cyc = 0;
  int mlat = 18;
  bit nodone = 1'b0;
  logic [31:0] salt = '0;
  logic [IW-1:0] nk;

  lds_circle_angle_sequencer #(.INDEX_W(IW), .ANGLE_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load), .seed_value(seed_value),
    .cordic_ready(cordic_ready), .cordic_done(cordic_done), .cordic_cos(cordic_cos),
    .cordic_sin(cordic_sin), .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
    .out_index(out_index), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference angle: floor(vdc2(k) * 2^16), built digit by digit from k.
  function automatic logic [15:0] ref_angle(input logic [IW-1:0] kk);
    int unsigned n, r;
    n = kk % 65536;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      r = r * 2 + (n % 2);
      n = n / 2;
    end
    return 16'(r);
  endfunction

  function automatic logic [31:0] f_cos(input logic [15:0] a);
    return {a, a ^ 16'hC3A5} ^ salt;
  endfunction
  function automatic logic [31:0] f_sin(input logic [15:0] a);
    return {~a, a} + salt;
  endfunction

  // CORDIC stand-in: done arrives L cycles after the start cycle.
  logic        mbusy;
  int          mcnt;
  logic [15:0] mang;
  assign cordic_ready = !mbusy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0; mcnt <= 0; mang <= '0;
      cordic_done <= 1'b0; cordic_cos <= '0; cordic_sin <= '0;
    end else begin
      cordic_done <= 1'b0;
      if (mbusy) begin
        if (mcnt == mlat - 1) begin
          mbusy       <= 1'b0;
          cordic_done <= !nodone;
          cordic_cos  <= f_cos(mang);
          cordic_sin  <= f_sin(mang);
        end else mcnt <= mcnt + 1;
      end else if (cordic_start) begin
        mbusy <= 1'b1; mcnt <= 1; mang <= cordic_angle;
      end
    end
  end

  task automatic wait_start(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cordic_start) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic wait_valid(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cordic_start, cordic_angle, out_valid, busy, timeout_err} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0", {cordic_start, cordic_angle, out_valid, busy, timeout_err});
    end
    checks++;
    if ({out_cos, out_sin, out_index} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {out_cos, out_sin, out_index});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cordic_start !== 1'b0) begin
      errors++; $display("FAIL idle_disabled: busy=%b start=%b want 0 0", busy, cordic_start);
    end
    nk = 1;
  endtask

  task automatic test_sequence();
    int ts, tv, prev;
    bit ok;
    salt = $urandom; mlat = 18; out_ready = 1'b1; enable = 1'b1; prev = 0;
    for (int p = 0; p < 4; p++) begin
      wait_start(ts, ok);
      if (p == 3) enable = 1'b0;
      checks++;
      if (!ok || cordic_angle !== ref_angle(nk)) begin
        errors++; $display("FAIL seq_angle k=%0d: got %h (seen=%b) want %h", nk, cordic_angle, ok, ref_angle(nk));
      end
      if (p > 0) begin
        checks++;
        if (ts - prev != mlat + 3) begin
          errors++; $display("FAIL seq_period: got %0d want %0d", ts - prev, mlat + 3);
        end
      end
      prev = ts;
      @(negedge clk);
      checks++;
      if (cordic_start !== 1'b0) begin
        errors++; $display("FAIL start_width: got %b want 0", cordic_start);
      end
      wait_valid(tv, ok);
      checks++;
      if (!ok || tv - ts != mlat + 1) begin
        errors++; $display("FAIL seq_latency: got %0d (seen=%b) want %0d", tv - ts, ok, mlat + 1);
      end
      checks++;
      if (out_index !== nk || out_cos !== f_cos(ref_angle(nk)) || out_sin !== f_sin(ref_angle(nk))) begin
        errors++; $display("FAIL seq_point: got %h %h %h want %h %h %h", out_index, out_cos, out_sin,
                           nk, f_cos(ref_angle(nk)), f_sin(ref_angle(nk)));
      end
      nk++;
    end
    drain();
  endtask

  task automatic test_backpressure();
    int ts, tv;
    bit ok, bad;
    logic [DW+DW+IW-1:0] snap;
    salt = $urandom; mlat = $urandom_range(4, 20); out_ready = 1'b0; enable = 1'b1;
    wait_start(ts, ok);
    wait_valid(tv, ok);
    snap = {out_cos, out_sin, out_index};
    checks++;
    if (!ok || out_index !== nk || out_cos !== f_cos(ref_angle(nk))) begin
      errors++; $display("FAIL bp_point: got %h %h want %h %h", out_index, out_cos, nk, f_cos(ref_angle(nk)));
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || cordic_start || {out_cos, out_sin, out_index} !== snap) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_stable: got unstable/start want stable hold");
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || cordic_start !== 1'b0) begin
      errors++; $display("FAIL bp_accept: valid=%b start=%b want 0 0", out_valid, cordic_start);
    end
    @(negedge clk);
    enable = 1'b0;
    nk++;
    checks++;
    if (cordic_start !== 1'b1 || cordic_angle !== ref_angle(nk)) begin
      errors++; $display("FAIL bp_restart: start=%b angle=%h want 1 %h", cordic_start, cordic_angle, ref_angle(nk));
    end
    wait_valid(tv, ok);
    checks++;
    if (!ok || out_index !== nk) begin
      errors++; $display("FAIL bp_next: got %h want %h", out_index, nk);
    end
    nk++;
    drain();
  endtask

  task automatic test_seed_wait();
    int ts, tv;
    bit ok, bad;
    salt = $urandom; mlat = 20; out_ready = 1'b1; enable = 1'b1;
    wait_start(ts, ok);
    repeat (3) @(negedge clk);
    seed_value = 5; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL seed_abort: valid=%b busy=%b want 0 0", out_valid, busy);
    end
    bad = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
      if (cordic_start) begin ok = 1'b1; break; end
    end
    enable = 1'b0;
    checks++;
    if (bad || !ok || cordic_angle !== 16'h6000) begin
      errors++; $display("FAIL seed_next: late_valid=%b started=%b angle=%h want 0 1 6000", bad, ok, cordic_angle);
    end
    wait_valid(tv, ok);
    checks++;
    if (!ok || out_index !== 32'd6 || out_sin !== f_sin(16'h6000)) begin
      errors++; $display("FAIL seed_point: got %h %h want 6 %h", out_index, out_sin, f_sin(16'h6000));
    end
    nk = 7;
    drain();
  endtask

  task automatic test_timeout();
    int ts;
    bit ok, bad;
    logic [IW-1:0] sv;
    nodone = 1'b1; mlat = 10; enable = 1'b1;
    wait_start(ts, ok);
    enable = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (timeout_err || !busy) bad = 1'b1;
    end
    checks++;
    if (!ok || bad) begin
      errors++; $display("FAIL to_early: started=%b early_exit=%b want 1 0", ok, bad);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL to_flag: err=%b busy=%b valid=%b want 1 0 0", timeout_err, busy, out_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b want 1", timeout_err);
    end
    sv = $urandom; seed_value = sv; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_clear: got %b want 0", timeout_err);
    end
    nk = sv + 1;
    nodone = 1'b0;
    drain();
  endtask

  task automatic test_enable_drop();
    int ts, tv;
    bit ok, bad;
    salt = $urandom; mlat = 12; out_ready = 1'b1; enable = 1'b1;
    wait_start(ts, ok);
    enable = 1'b0;
    wait_valid(tv, ok);
    checks++;
    if (!ok || out_index !== nk || out_cos !== f_cos(ref_angle(nk))) begin
      errors++; $display("FAIL endrop_point: got %h %h want %h %h", out_index, out_cos, nk, f_cos(ref_angle(nk)));
    end
    nk++;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || cordic_start) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL endrop_idle: got activity want idle");
    end
  endtask

  task automatic test_wrap();
    int ts, tv;
    bit ok;
    logic [IW-1:0] exp_k [2];
    logic [AW-1:0] exp_a [2];
    exp_k[0] = 32'hFFFF_FFFF; exp_k[1] = 32'h0;
    exp_a[0] = 16'hFFFF;      exp_a[1] = 16'h0000;
    salt = $urandom; mlat = 6; out_ready = 1'b1;
    seed_value = 32'hFFFF_FFFE; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; enable = 1'b1;
    for (int p = 0; p < 2; p++) begin
      wait_start(ts, ok);
      if (p == 1) enable = 1'b0;
      checks++;
      if (!ok || cordic_angle !== exp_a[p]) begin
        errors++; $display("FAIL wrap_angle%0d: got %h want %h", p, cordic_angle, exp_a[p]);
      end
      wait_valid(tv, ok);
      checks++;
      if (!ok || out_index !== exp_k[p] || timeout_err !== 1'b0) begin
        errors++; $display("FAIL wrap_index%0d: got %h err=%b want %h", p, out_index, timeout_err, exp_k[p]);
      end
    end
    nk = 1;
    drain();
  endtask

  task automatic test_random();
    int ts, tv, d;
    bit ok, bad;
    logic [IW-1:0] sv;
    for (int r = 0; r < 8; r++) begin
      salt = $urandom; mlat = $urandom_range(2, 25);
      if ($urandom_range(0, 2) == 0) begin
        sv = $urandom; seed_value = sv; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        nk = sv + 1;
      end
      out_ready = 1'b0; enable = 1'b1;
      wait_start(ts, ok);
      enable = 1'b0;
      checks++;
      if (!ok || cordic_angle !== ref_angle(nk)) begin
        errors++; $display("FAIL rnd_angle k=%h: got %h want %h", nk, cordic_angle, ref_angle(nk));
      end
      wait_valid(tv, ok);
      checks++;
      if (!ok || tv - ts != mlat + 1 || out_index !== nk ||
          out_cos !== f_cos(ref_angle(nk)) || out_sin !== f_sin(ref_angle(nk))) begin
        errors++; $display("FAIL rnd_point k=%h: got %h %h %h lat=%0d want %h %h lat=%0d", nk, out_index, out_cos,
                           out_sin, tv - ts, f_cos(ref_angle(nk)), f_sin(ref_angle(nk)), mlat + 1);
      end
      d = $urandom_range(0, 5);
      bad = 1'b0;
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        if (!out_valid || out_index !== nk) bad = 1'b1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (bad || out_valid !== 1'b0) begin
        errors++; $display("FAIL rnd_handshake k=%h: unstable=%b valid=%b want 0 0", nk, bad, out_valid);
      end
      nk++;
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_seed_wait();
    test_timeout();
    test_enable_drop();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
